pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 104 ++++++++++
 tb/tb_pipe_stage_reg.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Two-entry skid-buffer pipeline stage with flush and a saturating
//             downstream-stall counter.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
   parameter int                DATA_W     = 64,
   parameter logic [DATA_W-1:0] BUBBLE_VAL = {DATA_W{1'b0}},
   parameter int                CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_FULL  = 2'd1;
   localparam logic [1:0] S_SKID  = 2'd2;

   logic [1:0]        state_q,     state_d;
   logic [DATA_W-1:0] main_q,      main_d;
   logic [DATA_W-1:0] skid_q,      skid_d;
   logic              in_ready_q,  in_ready_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_EMPTY;
         main_q      <= BUBBLE_VAL;
         skid_q      <= BUBBLE_VAL;
         in_ready_q  <= 1'b1;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
         state_d = S_EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end else begin
         case (state_q)
            S_EMPTY: begin
               if (in_valid) begin
                  state_d = S_FULL;
                  main_d  = in_data;
               end
            end
            S_FULL: begin
               if (out_ready && in_valid) begin
                  main_d = in_data;
               end else if (out_ready) begin
                  state_d = S_EMPTY;
               end else if (in_valid) begin
                  state_d = S_SKID;
                  skid_d  = in_data;
               end
            end
            S_SKID: begin
               // in_ready is low here, so in_data is never sampled
               if (out_ready) begin
                  state_d = S_FULL;
                  main_d  = skid_q;
               end
            end
            default: state_d = S_EMPTY;
         endcase
      end
      // Registered ready: looks only at the next state, never at out_ready
      in_ready_d = (state_d != S_SKID);
   end

   always_comb begin
      out_valid   = (state_q != S_EMPTY);
      out_data    = out_valid ? main_q : BUBBLE_VAL;
      stall_cnt_d = stall_cnt_q;
      if (out_valid && !out_ready && !(&stall_cnt_q)) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   assign in_ready  = in_ready_q;
   assign stall_cnt = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Testbench for pipe_stage_reg: directed vectors plus a reference-queue run.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_data;
   logic [3:0]  stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pipe_stage_reg #(
      .DATA_W    (64),
      .BUBBLE_VAL(64'h0),
      .CNT_W     (4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .flush    (flush),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [63:0] q[$];
   logic        m_ready;
   logic [3:0]  m_cnt;

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; out_ready = 1'b0;
      #12;
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_data",  out_data,       64'd0);
      check_eq("rst_in_ready",  64'(in_ready),  64'd1);
      check_eq("rst_stall_cnt", 64'(stall_cnt), 64'd0);
      reset = 1'b1;

      // Stream 1..5 with downstream always ready
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_data = 64'(i);
         step();
         check_eq("stream_valid", 64'(out_valid), 64'd1);
         check_eq("stream_data",  out_data,       64'(i));
         check_eq("stream_ready", 64'(in_ready),  64'd1);
      end
      in_valid = 1'b0;
      step();
      check_eq("stream_drain_valid", 64'(out_valid), 64'd0);
      check_eq("stream_drain_data",  out_data,       64'd0);
      check_eq("stream_stall_cnt",   64'(stall_cnt), 64'd0);

      // Backpressure into SKID, then drain in order
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA; step();
      check_eq("bp_a_data",  out_data,      64'hA);
      check_eq("bp_a_ready", 64'(in_ready), 64'd1);
      in_data   = 64'hB; step();
      check_eq("bp_skid_ready", 64'(in_ready), 64'd0);
      check_eq("bp_skid_data",  out_data,      64'hA);
      in_data   = 64'hC; step();
      check_eq("bp_hold_ready", 64'(in_ready),  64'd0);
      check_eq("bp_hold_data",  out_data,       64'hA);
      check_eq("bp_stall_cnt",  64'(stall_cnt), 64'd2);
      out_ready = 1'b1; step();
      check_eq("bp_drain_b", out_data,      64'hB);
      check_eq("bp_ready_b", 64'(in_ready), 64'd1);
      step();
      check_eq("bp_drain_c", out_data, 64'hC);
      in_valid = 1'b0; step();
      check_eq("bp_empty_valid", 64'(out_valid), 64'd0);
      check_eq("bp_final_cnt",   64'(stall_cnt), 64'd2);

      // Flush while SKID holds A/B with C offered
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 64'hA; step();
      in_data   = 64'hB; step();
      check_eq("fl_pre_ready", 64'(in_ready), 64'd0);
      in_data = 64'hC; flush = 1'b1; step();
      flush = 1'b0;
      check_eq("fl_valid",     64'(out_valid), 64'd0);
      check_eq("fl_data",      out_data,       64'd0);
      check_eq("fl_ready",     64'(in_ready),  64'd1);
      check_eq("fl_stall_cnt", 64'(stall_cnt), 64'd4);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check_eq("fl_no_ghost", 64'(out_valid), 64'd0);
      end

      // Saturation of the stall counter
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 64'h7; step();
      in_valid  = 1'b0;
      for (int i = 0; i < 20; i++) step();
      check_eq("sat_cnt",  64'(stall_cnt), 64'hF);
      check_eq("sat_data", out_data,       64'h7);
      step();
      check_eq("sat_hold", 64'(stall_cnt), 64'hF);
      flush = 1'b1; step(); flush = 1'b0;
      check_eq("sat_after_flush",  64'(stall_cnt), 64'hF);
      check_eq("sat_flush_valid",  64'(out_valid), 64'd0);

      // Asynchronous reset between edges while FULL with 0x55
      in_valid = 1'b1; in_data = 64'h55; step();
      in_valid = 1'b0;
      check_eq("ar_pre_data", out_data, 64'h55);
      #2 reset = 1'b0;
      #1;
      check_eq("ar_valid", 64'(out_valid), 64'd0);
      check_eq("ar_data",  out_data,       64'd0);
      check_eq("ar_cnt",   64'(stall_cnt), 64'd0);
      check_eq("ar_ready", 64'(in_ready),  64'd1);
      #1 reset = 1'b1;
      out_ready = 1'b1; in_valid = 1'b1; in_data = 64'h66; step();
      in_valid = 1'b0;
      check_eq("ar_post_valid", 64'(out_valid), 64'd1);
      check_eq("ar_post_data",  out_data,       64'h66);
      step();

      // Random traffic against a reference queue
      q.delete();
      m_ready = 1'b1;
      m_cnt   = stall_cnt;
      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         in_data   = {$urandom, $urandom};
         if (q.size() > 0 && !out_ready && m_cnt != 4'hF) m_cnt = m_cnt + 4'd1;
         if (flush) begin
            q.delete();
         end else begin
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (in_valid && m_ready) q.push_back(in_data);
         end
         m_ready = (q.size() < 2);
         step();
         check_eq("rnd_valid", 64'(out_valid), 64'(q.size() > 0));
         check_eq("rnd_data",  out_data,       (q.size() > 0) ? q[0] : 64'd0);
         check_eq("rnd_ready", 64'(in_ready),  64'(m_ready));
         check_eq("rnd_cnt",   64'(stall_cnt), 64'(m_cnt));
      end
      flush = 1'b0; in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
